// File: rtl/alu_seq_core.sv
// Registered ALU with a start/busy/done handshake: bitwise, ADD and SUB finish in one EXEC cycle.
// MUL (shift-add) and DIV (restoring) take WIDTH EXEC cycles; results hold until the next completion.
module alu_seq_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       Selector,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Hi,
   output logic             Cout,
   output logic             Ov,
   output logic             zero,
   output logic             error,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_NOT = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q;
   logic [WIDTH:0]   w_hi;
   logic [WIDTH-1:0] w_lo;
   logic [CW-1:0]    cnt;

   logic             div_zero, iterative;
   logic [WIDTH:0]   mul_sum, div_shift, div_trial;
   logic [WIDTH:0]   step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH:0]   add_full, sub_full;
   logic [WIDTH-1:0] res_s, res_hi;
   logic             res_cout, res_ov, res_err;

   assign div_zero  = (op_q == OP_DIV) && (b_q == '0);
   assign iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && !div_zero);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = EXEC;
         EXEC:    if (!iterative || (cnt == CW'(WIDTH - 1))) state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // One iteration of MUL or DIV on the {w_hi, w_lo} work pair
   always_comb begin
      mul_sum   = w_lo[0] ? (w_hi + {1'b0, a_q}) : w_hi;
      div_shift = {w_hi[WIDTH-1:0], w_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, b_q};
      step_hi   = '0;
      step_lo   = '0;
      if (op_q == OP_MUL) begin
         step_hi = {1'b0, mul_sum[WIDTH:1]};
         step_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
         step_hi = div_trial;
         step_lo = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = div_shift;
         step_lo = {w_lo[WIDTH-2:0], 1'b0};
      end
   end

   // Final result selection, registered on the FIN edge
   always_comb begin
      add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
      sub_full = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
      res_s    = '0;
      res_hi   = '0;
      res_cout = 1'b0;
      res_ov   = 1'b0;
      res_err  = 1'b0;
      case (op_q)
         OP_NOT: res_s = ~a_q;
         OP_ADD: begin
            res_s    = add_full[WIDTH-1:0];
            res_cout = add_full[WIDTH];
            res_ov   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_s[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_s    = sub_full[WIDTH-1:0];
            res_cout = sub_full[WIDTH];
            res_ov   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_s[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_MUL: begin
            res_s  = w_lo;
            res_hi = w_hi[WIDTH-1:0];
         end
         OP_DIV: begin
            if (div_zero) begin
               res_s   = '1;
               res_hi  = a_q;
               res_err = 1'b1;
            end else begin
               res_s  = w_lo;
               res_hi = w_hi[WIDTH-1:0];
            end
         end
         OP_AND:  res_s = a_q & b_q;
         OP_OR:   res_s = a_q | b_q;
         OP_XOR:  res_s = a_q ^ b_q;
         default: res_s = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
         w_hi  <= '0;
         w_lo  <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         S     <= '0;
         Hi    <= '0;
         Cout  <= 1'b0;
         Ov    <= 1'b0;
         zero  <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= state_n;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= Selector;
                  a_q   <= A;
                  b_q   <= B;
                  cin_q <= Cin;
                  w_hi  <= '0;
                  // MUL shifts the multiplier out of w_lo; DIV shifts the dividend out
                  w_lo  <= (Selector == OP_DIV) ? A : B;
                  cnt   <= '0;
               end
            end
            EXEC: begin
               if (iterative) begin
                  w_hi <= step_hi;
                  w_lo <= step_lo;
                  cnt  <= cnt + CW'(1);
               end
            end
            FIN: begin
               S     <= res_s;
               Hi    <= res_hi;
               Cout  <= res_cout;
               Ov    <= res_ov;
               zero  <= (res_s == '0);
               error <= res_err;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: an 8-bit instance for the main scenarios, a 16-bit one for wide MUL.
module tb_alu_seq_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] sel;
   logic [7:0] a, b;
   logic       cin;
   logic       busy, done, cout, ov, zero, error;
   logic [7:0] s, hi;
   logic [1:0] dbg_state;

   logic        start16;
   logic [2:0]  sel16;
   logic [15:0] a16, b16;
   logic        busy16, done16, cout16, ov16, zero16, error16;
   logic [15:0] s16, hi16;
   logic [1:0]  dbg_state16;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_seq_core #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .Selector(sel), .A(a), .B(b), .Cin(cin),
      .busy(busy), .done(done), .S(s), .Hi(hi), .Cout(cout), .Ov(ov), .zero(zero),
      .error(error), .dbg_state(dbg_state)
   );

   alu_seq_core #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .Selector(sel16), .A(a16), .B(b16), .Cin(1'b0),
      .busy(busy16), .done(done16), .S(s16), .Hi(hi16), .Cout(cout16), .Ov(ov16), .zero(zero16),
      .error(error16), .dbg_state(dbg_state16)
   );

   // Drive a request #1 after an edge, let it be accepted, then count edges until done.
   // lat = number of edges after the accept edge; -1 on timeout.
   task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic c, output int lat);
      sel = op; a = x; b = y; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sel = '0; a = '0; b = '0; cin = 1'b0;
      start16 = 1'b0; sel16 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, s, hi, cout, ov, zero, error} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b S=%h Hi=%h Cout=%b Ov=%b zero=%b err=%b, want all 0",
                  busy, done, s, hi, cout, ov, zero, error);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_sub();
      int lat;
      run_op(3'b001, 8'd200, 8'd100, 1'b0, lat);
      n_cmp++;
      if ({s, cout, ov, zero, error, hi} !== {8'd44, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0} || lat != 2) begin
         n_bad++;
         $display("FAIL add_200_100: got S=%0d Cout=%b Ov=%b zero=%b Hi=%0d lat=%0d, want S=44 Cout=1 Ov=0 zero=0 Hi=0 lat=2",
                  s, cout, ov, zero, hi, lat);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || s !== 8'd44) begin
         n_bad++;
         $display("FAIL done_single_pulse: got done=%b S=%0d, want done=0 S=44", done, s);
      end
      run_op(3'b010, 8'd5, 8'd5, 1'b0, lat);
      n_cmp++;
      if ({s, zero, cout, ov} !== {8'd0, 1'b1, 1'b0, 1'b0} || lat != 2) begin
         n_bad++;
         $display("FAIL sub_5_5: got S=%0d zero=%b Cout=%b Ov=%b lat=%0d, want S=0 zero=1 Cout=0 Ov=0 lat=2",
                  s, zero, cout, ov, lat);
      end
      run_op(3'b010, 8'd3, 8'd4, 1'b0, lat);
      n_cmp++;
      if ({s, zero, cout, ov} !== {8'd255, 1'b0, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL sub_3_4: got S=%0d zero=%b Cout=%b Ov=%b, want S=255 zero=0 Cout=1 Ov=0", s, zero, cout, ov);
      end
      run_op(3'b001, 8'd127, 8'd1, 1'b0, lat);
      n_cmp++;
      if ({s, cout, ov} !== {8'd128, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL add_overflow: got S=%0d Cout=%b Ov=%b, want S=128 Cout=0 Ov=1", s, cout, ov);
      end
      // Cin feeds both ADD and SUB; 0x80 - 0x01 - 1 = 0x7E with signed overflow
      run_op(3'b010, 8'h80, 8'h01, 1'b1, lat);
      n_cmp++;
      if ({s, cout, ov} !== {8'h7E, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL sub_borrow_in: got S=%h Cout=%b Ov=%b, want S=7e Cout=0 Ov=1", s, cout, ov);
      end
   endtask

   task automatic test_logic();
      int lat;
      run_op(3'b000, 8'hA5, 8'h00, 1'b1, lat);
      n_cmp++;
      if ({s, hi, cout, ov} !== {8'h5A, 8'h00, 1'b0, 1'b0} || lat != 2) begin
         n_bad++;
         $display("FAIL not_a5: got S=%h Hi=%h Cout=%b Ov=%b lat=%0d, want S=5a Hi=00 Cout=0 Ov=0 lat=2", s, hi, cout, ov, lat);
      end
      run_op(3'b101, 8'hF0, 8'h3C, 1'b0, lat);
      n_cmp++;
      if (s !== 8'h30) begin
         n_bad++;
         $display("FAIL and: got S=%h, want 30", s);
      end
      run_op(3'b110, 8'hF0, 8'h3C, 1'b0, lat);
      n_cmp++;
      if (s !== 8'hFC) begin
         n_bad++;
         $display("FAIL or: got S=%h, want fc", s);
      end
      run_op(3'b111, 8'h3C, 8'h3C, 1'b0, lat);
      n_cmp++;
      if (s !== 8'h00 || zero !== 1'b1) begin
         n_bad++;
         $display("FAIL xor_zero: got S=%h zero=%b, want S=00 zero=1", s, zero);
      end
   endtask

   task automatic test_mul();
      int lat;
      sel = 3'b011; a = 8'd13; b = 8'd21; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || s !== 8'h00) begin
         n_bad++;
         $display("FAIL mul_busy_hold: got busy=%b S=%h, want busy=1 S=00 held", busy, s);
      end
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      n_cmp++;
      if ({s, hi} !== {8'h11, 8'h01} || lat != 9) begin
         n_bad++;
         $display("FAIL mul_13_21: got S=%h Hi=%h lat=%0d, want S=11 Hi=01 lat=9", s, hi, lat);
      end
      run_op(3'b011, 8'd255, 8'd255, 1'b1, lat);
      n_cmp++;
      if ({s, hi, cout, ov, zero} !== {8'h01, 8'hFE, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL mul_255_255: got S=%h Hi=%h Cout=%b Ov=%b zero=%b, want S=01 Hi=fe 0 0 0", s, hi, cout, ov, zero);
      end
   endtask

   task automatic test_div();
      int lat;
      run_op(3'b100, 8'd200, 8'd7, 1'b0, lat);
      n_cmp++;
      if ({s, hi, error} !== {8'd28, 8'd4, 1'b0} || lat != 9) begin
         n_bad++;
         $display("FAIL div_200_7: got S=%0d Hi=%0d err=%b lat=%0d, want S=28 Hi=4 err=0 lat=9", s, hi, error, lat);
      end
      run_op(3'b100, 8'd9, 8'd0, 1'b0, lat);
      n_cmp++;
      if ({s, hi, error, zero} !== {8'd255, 8'd9, 1'b1, 1'b0} || lat != 2) begin
         n_bad++;
         $display("FAIL div_by_zero: got S=%0d Hi=%0d err=%b zero=%b lat=%0d, want S=255 Hi=9 err=1 zero=0 lat=2",
                  s, hi, error, zero, lat);
      end
      run_op(3'b100, 8'd3, 8'd10, 1'b0, lat);
      n_cmp++;
      if ({s, hi, error, zero} !== {8'd0, 8'd3, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL div_3_10: got S=%0d Hi=%0d err=%b zero=%b, want S=0 Hi=3 err=0 zero=1", s, hi, error, zero);
      end
   endtask

   task automatic test_ignore_and_back_to_back();
      int lat;
      sel = 3'b011; a = 8'd13; b = 8'd21; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sel = 3'b001; a = 8'd1; b = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int i = 4; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      n_cmp++;
      if ({s, hi} !== {8'h11, 8'h01} || lat != 9) begin
         n_bad++;
         $display("FAIL start_while_busy: got S=%h Hi=%h lat=%0d, want S=11 Hi=01 lat=9", s, hi, lat);
      end
      // Still in the done cycle: a new request must be taken immediately
      sel = 3'b001; a = 8'd10; b = 8'd20; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL back_to_back_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
      end
      @(posedge clk); @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b1 || s !== 8'd31) begin
         n_bad++;
         $display("FAIL back_to_back_result: got done=%b S=%0d, want done=1 S=31", done, s);
      end
   endtask

   task automatic test_mid_reset();
      int seen;
      sel = 3'b011; a = 8'd255; b = 8'd255; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if ({busy, done, s, hi, cout, ov, zero, error} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: got busy=%b done=%b S=%h Hi=%h Cout=%b Ov=%b zero=%b err=%b, want all 0",
                  busy, done, s, hi, cout, ov, zero, error);
      end
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++;
         $display("FAIL mid_reset_no_done: got %0d cycles with done/busy, want 0", seen);
      end
   endtask

   task automatic test_mul_wide();
      int lat;
      sel16 = 3'b011; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = i;
            break;
         end
      end
      n_cmp++;
      if ({s16, hi16, zero16, error16, cout16, ov16, busy16} !== {16'h0001, 16'hFFFE, 5'b0} || lat != 17) begin
         n_bad++;
         $display("FAIL mul16_ffff: got S=%h Hi=%h lat=%0d, want S=0001 Hi=fffe lat=17", s16, hi16, lat);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_mul();
      test_div();
      test_ignore_and_back_to_back();
      test_mid_reset();
      test_mul_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
